// File: rtl/code_counter_sched.sv
// Two-requester scheduler sharing one code_counter: clears it, steps it len times, stops early on TERM_CODE.
// Optional `SCHED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module code_counter_sched #(
    parameter int unsigned LEN_W     = 4,
    parameter logic [3:0]  TERM_CODE = 4'hF
) (
    input  logic             cp,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [3:0]       code,
    output logic             clr,
    output logic             x,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             term,
    output logic [LEN_W:0]   steps
);

    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               id_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;
`ifndef SCHED_PRIO_EN
    logic               ptr_q;
`endif

    logic               win_c;
    logic [LEN_W-1:0]   len_sel_c;
    logic [CNT_W-1:0]   len_eff_c;
    logic               last_c;
    logic               hit_term_c;

    // Arbitration: a lone request wins outright; a tie goes to the pointer (or requester 0).
    always_comb begin
        win_c = 1'b0;
`ifdef SCHED_PRIO_EN
        win_c = ~req[0];
`else
        if (req == 2'b11) begin
            win_c = ptr_q;
        end else begin
            win_c = req[1];
        end
`endif
        len_sel_c = win_c ? len1 : len0;
        // A zero length encodes the full 2^LEN_W step range.
        if (len_sel_c == '0) begin
            len_eff_c = {1'b1, {LEN_W{1'b0}}};
        end else begin
            len_eff_c = CNT_W'(len_sel_c);
        end
    end

    assign hit_term_c = (code == TERM_CODE);
    assign last_c     = (cnt_q == (len_q - CNT_W'(1)));
    assign x          = (state_q == S_RUN) && !hit_term_c;

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            id_q    <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            clr     <= 1'b0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            term    <= 1'b0;
            steps   <= '0;
`ifndef SCHED_PRIO_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        id_q    <= win_c;
                        len_q   <= len_eff_c;
                        cnt_q   <= '0;
                        gnt     <= win_c ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        clr     <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr     <= 1'b0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // Terminal code wins over the length check.
                    if (hit_term_c) begin
                        term    <= 1'b1;
                        steps   <= cnt_q;
                        done    <= 1'b1;
                        done_id <= id_q;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_c) begin
                            term    <= 1'b0;
                            steps   <= cnt_q + CNT_W'(1);
                            done    <= 1'b1;
                            done_id <= id_q;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
`ifndef SCHED_PRIO_EN
                    ptr_q   <= ~id_q;
`endif
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_counter_sched.sv
// Randomized self-checking bench for code_counter_sched with a job-level reference model
// and a behavioural code_counter that can be told to show the terminal code after N steps.
module tb_code_counter_sched;

    logic       cp;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [3:0] code;
    logic       clr;
    logic       x;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       term;
    logic [4:0] steps;

    int n_tests = 0;
    int n_fail  = 0;
    int cn      = 0;
    int term_at = 0;
    int m_ptr   = 0;

    code_counter_sched #(.LEN_W(4), .TERM_CODE(4'hF)) dut (
        .cp      (cp),
        .reset   (reset),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .code    (code),
        .clr     (clr),
        .x       (x),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .term    (term),
        .steps   (steps)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    // Counter model: sync clear, steps on x, shows F once term_at steps have been taken.
    always @(posedge cp) begin
        if (clr) cn <= 0;
        else if (x) cn <= cn + 1;
    end

    always_comb begin
        if (term_at != 0 && cn >= term_at) code = 4'hF;
        else code = 4'(cn % 15);
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_job(input logic [1:0] r, input int l0, input int l1, input int tat);
        int win, le, es, et, nx, nclr, cyc, first_x, gnt_bad, exp_gnt;
        bit seen;
        nx = 0; nclr = 0; cyc = 0; first_x = -1; gnt_bad = 0; seen = 0;
        @(negedge cp);
        req = r; len0 = 4'(l0); len1 = 4'(l1); term_at = tat;
`ifdef SCHED_PRIO_EN
        win = r[0] ? 0 : 1;
`else
        win = (r == 2'b11) ? m_ptr : (r[1] ? 1 : 0);
`endif
        le = (win == 1) ? l1 : l0;
        if (le == 0) le = 16;
        if (tat != 0 && tat < le) begin es = tat; et = 1; end
        else begin es = le; et = 0; end
        exp_gnt = (win == 1) ? 2 : 1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge cp);
            #1;
            cyc = c;
            if (clr) nclr++;
            if (x) begin
                nx++;
                if (first_x < 0) first_x = c;
            end
            if (int'(gnt) != exp_gnt || !busy) gnt_bad++;
            // Mid-job input changes must be ignored.
            if (c == 1) begin
                len0 = 4'($urandom);
                len1 = 4'($urandom);
                req  = 2'($urandom);
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        check_eq("done_seen", int'(seen), 1);
        check_eq("done_id", int'(done_id), win);
        check_eq("steps", int'(steps), es);
        check_eq("term", int'(term), et);
        check_eq("x_cycles", nx, es);
        check_eq("clr_cycles", nclr, 1);
        check_eq("first_x_latency", first_x, 2);
        check_eq("job_cycles", cyc, es + 2 + et);
        check_eq("gnt_held", gnt_bad, 0);
        req = 2'b00;
        @(posedge cp);
        #1;
        check_eq("post_done", int'(done), 0);
        check_eq("post_busy", int'(busy), 0);
        check_eq("post_gnt", int'(gnt), 0);
        check_eq("steps_hold", int'(steps), es);
        check_eq("term_hold", int'(term), et);
        m_ptr = 1 - win;
    endtask

    task automatic reset_mid_job();
        int pulses;
        pulses = 0;
        @(negedge cp);
        req = 2'b01; len0 = 4'd5; term_at = 0;
        repeat (4) @(posedge cp);
        #1;
        check_eq("rst_pre_x", int'(x), 1);
        @(negedge cp);
        reset = 1'b1;
        #1;
        check_eq("rst_x", int'(x), 0);
        check_eq("rst_gnt", int'(gnt), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_clr", int'(clr), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge cp);
            #1;
            if (done) pulses++;
        end
        check_eq("rst_no_done", pulses, 0);
        @(negedge cp);
        reset = 1'b0;
        req = 2'b00;
        m_ptr = 0;
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
        repeat (2) @(negedge cp);
        check_eq("reset_clr", int'(clr), 0);
        check_eq("reset_x", int'(x), 0);
        check_eq("reset_gnt", int'(gnt), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_done_id", int'(done_id), 0);
        check_eq("reset_term", int'(term), 0);
        check_eq("reset_steps", int'(steps), 0);
        reset = 1'b0;

        do_job(2'b11, 2, 4, 0);
        do_job(2'b11, 2, 4, 0);
        do_job(2'b01, 3, 0, 0);
        do_job(2'b10, 0, 0, 0);
        do_job(2'b01, 15, 0, 6);
        do_job(2'b11, 1, 7, 0);
        do_job(2'b11, 1, 7, 0);
        reset_mid_job();
        do_job(2'b11, 3, 5, 0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] r;
            int tat;
            r = 2'(1 + $urandom_range(2));
            tat = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(16, 1));
            do_job(r, int'($urandom_range(15)), int'($urandom_range(15)), tat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
